// File: rtl/fpu_seq.sv
// fpu_seq: issue/retire sequencer between execute and the FP units; one op in flight, tagged.
// Latency: response valid LAT(op)+1 edges after accept; LAT is 0 for sign-inject, compare and invalid ops.
// Backpressure: response held until resp_ready; a new request is taken on the same edge the response retires.
// Optional FPU_SEQ_PERF_EN adds perf_ops/perf_stall counters.
module fpu_seq #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 8,
  parameter int LAT_CVT  = 1,
  parameter int TAG_W    = 5,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_src0,
  input  logic [31:0]      req_src1,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [3:0]       unit_op,
  output logic [31:0]      unit_src0,
  output logic [31:0]      unit_src1,
  input  logic [31:0]      unit_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [TAG_W-1:0] resp_tag,
`ifdef FPU_SEQ_PERF_EN
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [31:0]      src0_q;
  logic [31:0]      src1_q;
  logic [TAG_W-1:0] tag_q;
  logic             resp_valid_q;
  logic [31:0]      resp_result_q;
  logic [TAG_W-1:0] resp_tag_q;

  logic [CNT_W-1:0] op_lat;
  logic             op_invalid;
  logic             accept;

  // Latency of the op currently held on the unit operand registers.
  always_comb begin
    op_lat     = '0;
    op_invalid = 1'b0;
    case (op_q)
      4'd0, 4'd1:   op_lat = CNT_W'(LAT_ADD);
      4'd2:         op_lat = CNT_W'(LAT_MUL);
      4'd3:         op_lat = CNT_W'(LAT_DIV);
      4'd4:         op_lat = CNT_W'(LAT_SQRT);
      4'd11, 4'd12: op_lat = CNT_W'(LAT_CVT);
      4'd13, 4'd14, 4'd15: op_invalid = 1'b1;
      default:      op_lat = '0;
    endcase
  end

  // Flush blocks acceptance so an abandoned slot cannot be refilled in the same cycle.
  always_comb begin
    req_ready = !flush && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
    accept    = req_valid && req_ready;
  end

  // Sequencer FSM: accept, count down the unit latency, hold the response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      src0_q        <= '0;
      src1_q        <= '0;
      tag_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_tag_q    <= '0;
    end else if (flush) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            src0_q  <= req_src0;
            src1_q  <= req_src1;
            tag_q   <= req_tag;
            cnt_q   <= '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == op_lat) begin
            resp_result_q <= op_invalid ? 32'h0 : unit_result;
            resp_tag_q    <= tag_q;
            resp_valid_q  <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            if (accept) begin
              op_q    <= req_op;
              src0_q  <= req_src0;
              src1_q  <= req_src1;
              tag_q   <= req_tag;
              cnt_q   <= '0;
              state_q <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPU_SEQ_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  // Event counters; deliberately untouched by flush so they span whole runs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (resp_valid_q && resp_ready) perf_ops_q <= perf_ops_q + 32'd1;
      if (req_valid && !req_ready)    perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

  assign unit_op     = op_q;
  assign unit_src0   = src0_q;
  assign unit_src1   = src1_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_tag    = resp_tag_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
- Parametrised issue/retire sequencer that sits between the core's execute stage and the FP arithmetic units.
- Accepts one FP operation per valid/ready handshake and holds its operands stable on registered outputs for the units.
- Waits the per-class latency set by a parameter, then captures the muxed unit result into a response register with valid/ready backpressure.
- Supersedes fixed-latency start/fin sequencing: latencies are configurable, each operation carries a tag, back-to-back issue is supported, and a flush input exists.

Parameters:
- LAT_ADD, 3, cycles for fadd/fsub (op 0-1)
- LAT_MUL, 3, cycles for fmul (op 2)
- LAT_DIV, 10, cycles for fdiv (op 3)
- LAT_SQRT, 8, cycles for fsqrt (op 4)
- LAT_CVT, 1, cycles for fcvt.w.s/fcvt.s.w (op 11-12)
- TAG_W, 5, width of the request/response tag
- CNT_W, 4, latency counter width; must hold the maximum LAT_*

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_op  in  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5-7 sgnj/sgnjn/sgnjx, 8-10 eq/le/lt, 11 cvt.w.s, 12 cvt.s.w
- req_src0  in  32  operand 0
- req_src1  in  32  operand 1
- req_tag  in  TAG_W  destination tag
- flush  in  1  abandon the in-flight operation
- unit_op  out  4  registered opcode to the units/result mux
- unit_src0  out  32  registered operand 0
- unit_src1  out  32  registered operand 1
- unit_result  in  32  result already muxed by unit_op
- resp_valid  out  1  response register valid
- resp_ready  in  1  consumer takes the response
- resp_result  out  32  captured result
- resp_tag  out  TAG_W  tag of the response
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; resp_valid 0; resp_result 0; resp_tag 0; unit_op/unit_src0/unit_src1 0; counter 0. Reset mid-operation discards the operation, and no response is produced.
- States: IDLE, EXEC, RESP.
- req_ready = !flush && (IDLE || (RESP && resp_ready)).
- Accept (req_valid && req_ready) at edge k:
  - op, src0, src1 and tag are registered.
  - state goes to EXEC and the counter to 0.
  - If accepted from RESP, resp_valid drops at the same edge (response consumed).
- EXEC: the counter increments each cycle. When counter == LAT(op), the next edge captures unit_result into resp_result and the tag into resp_tag, sets resp_valid, and moves to RESP.
  - resp_valid is therefore first high after edge k+LAT(op)+1.
- LAT(op) is 0 for ops 5-10 and for invalid ops 13-15. For invalid ops the captured result is forced to 0, ignoring unit_result.
- RESP: resp_valid is held with resp_result/resp_tag stable until resp_ready.
  - resp_ready without a new request: go to IDLE and clear resp_valid.
  - resp_ready with a new request: back-to-back accept (see Accept).
- unit_src0/unit_src1/unit_op remain constant from accept until the next accept. They do not change during EXEC.
- Flush: priority over everything except reset. At the next edge: state IDLE, resp_valid 0, counter 0; any accept in the same cycle is blocked via req_ready.
- resp_ready while in IDLE/EXEC: ignored.
- No more than one operation is in flight. Units may be pipelined internally; the sequencer relies only on the fixed latency.

Optional Feature:
- Macro FPU_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_ops[31:0] (increments on each response handshake, resp_valid && resp_ready) and perf_stall[31:0] (increments each cycle req_valid && !req_ready).
  - Both reset to 0, wrap at 2^32, and are not cleared by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- fadd: src0 0x3F800000, src1 0x40000000, tag 3, bench unit model returns 0x40400000 → resp_valid first high after accept edge+4, resp_result 0x40400000, resp_tag 3.
- Back-to-back: fsgnjn (op 6) then fmul, with resp_ready held 1 → second accept in the same cycle the first response retires; req_ready never drops for more than one EXEC period; tags in order.
- Backpressure: fdiv completes while resp_ready=0 for 5 cycles → resp_valid, resp_result and resp_tag stable, req_ready 0; retires on the first resp_ready cycle.
- Flush at EXEC counter 4 of fdiv (LAT 10) with req_valid=1 → no resp_valid ever for that tag; req_ready 0 in the flush cycle; IDLE next cycle; the following request completes normally.
- Invalid op 4'hF with unit_result 0xDEADBEEF → resp_valid after accept edge+1 with resp_result 0x00000000.
- Reset pulse during fsqrt EXEC → all outputs 0 the next cycle, and no response afterwards; with FPU_SEQ_PERF_EN defined, perf_ops/perf_stall read 0.
